// File: rtl/mem_store_buffer.sv
// mem_store_buffer: posted-write buffer between the MEM stage and data memory.
// Committed stores are queued in a small circular FIFO. They drain to memory
// in push order through a write/ack handshake. MEM-stage loads probe the
// buffer and get the data of the youngest pending store to the same word.
//
// Handshake semantics, for both sides:
//   - Store side: a store transfers on a rising edge where i_st_valid &&
//     o_st_ready. o_st_ready depends only on registered state (= !o_full).
//     A store presented while not ready is dropped, not stalled.
//   - Memory side: the head transfers on a rising edge where
//     o_mem_write && i_mem_ack. o_mem_write/o_mem_addr/o_mem_wdata are driven
//     only from registered state, so they stay stable until acked and never
//     depend combinationally on i_mem_ack. An ack while empty has no effect.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_st_valid,
  input  logic [AW-1:0]            i_st_addr,
  input  logic [DW-1:0]            i_st_data,
  output logic                     o_st_ready,
  input  logic                     i_ld_valid,
  input  logic [AW-1:0]            i_ld_addr,
  output logic                     o_ld_hit,
  output logic [DW-1:0]            o_ld_data,
  output logic                     o_mem_write,
  output logic [AW-1:0]            o_mem_addr,
  output logic [DW-1:0]            o_mem_wdata,
  input  logic                     i_mem_ack,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage; one full word per entry.
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  logic             push_en;
  logic             pop_en;
  logic             empty;
  logic             full;

  // Forwarding search scratch.
  logic [PW-1:0]    fwd_idx;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  // Byte-offset bits of the load address take no part in word matching.
  logic             unused_ld_lsb;
  assign unused_ld_lsb = ^i_ld_addr[1:0];

  // Full/empty are derived from the occupancy count, so equal pointers are
  // never ambiguous.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign push_en = i_st_valid && !full;
  assign pop_en  = !empty && i_mem_ack;

  // Circular FIFO update: write at wr_ptr, retire at rd_ptr, track occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Push and pop never target the same slot: that would need wr_ptr ==
      // rd_ptr with the buffer non-empty, i.e. full, and full blocks pushes.
      if (push_en) begin
        addr_q[wr_ptr]  <= i_st_addr;
        data_q[wr_ptr]  <= i_st_data;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop_en) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Store-to-load forwarding: walk from the youngest entry (wr_ptr-1) toward
  // the oldest and take the first valid word match. A store being pushed this
  // cycle is not yet in the array, so it is invisible until the next cycle;
  // the head being popped this cycle is still valid and still matches.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (i_ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = wr_ptr - PW'(1) - PW'(i);
        if (!fwd_hit && valid_q[fwd_idx] &&
            (addr_q[fwd_idx][AW-1:2] == i_ld_addr[AW-1:2])) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[fwd_idx];
        end
      end
    end
  end

  assign o_ld_hit    = fwd_hit;
  assign o_ld_data   = fwd_data;

  // Memory side shows the head entry whenever anything is pending; outputs
  // are zero while empty so the idle bus is quiet.
  assign o_mem_write = !empty;
  assign o_mem_addr  = empty ? '0 : addr_q[rd_ptr];
  assign o_mem_wdata = empty ? '0 : data_q[rd_ptr];

  assign o_count     = count_q;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_st_ready  = !full;

endmodule
